// File: rtl/clkmux_nx1_hs_pkg.sv
// Shared types and constants for the N:1 glitch-free clock mux with select handshake.
package clkmux_pkg;

    // Control FSM states (clk0 domain)
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_OFF_WAIT,
        ST_ON_WAIT,
        ST_FALLBACK
    } state_t;

    // Values reported on err_code
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_RANGE  = 2'd1;
    localparam logic [1:0] ERR_OFF_TO = 2'd2;
    localparam logic [1:0] ERR_ON_TO  = 2'd3;

endpackage

// File: rtl/clkmux_nx1_hs_if.sv
// Select handshake and status bundle between a requester and the clock mux.
interface clkmux_nx1_hs_if #(
    parameter int SEL_W = 2
);
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             sel_ready;
    logic             busy;
    logic [SEL_W-1:0] cur_sel;
    logic             err;
    logic [1:0]       err_code;

    // Requester side
    modport master (
        output sel, sel_valid,
        input  sel_ready, busy, cur_sel, err, err_code
    );

    // Clock mux side
    modport slave (
        input  sel, sel_valid,
        output sel_ready, busy, cur_sel, err, err_code
    );
endinterface

// File: rtl/clkmux_nx1_hs_gate_cell.sv
// One source's gate cell: enable synchronised into the source domain, gated on the
// falling edge so the output only opens/closes while the source is low, and the
// gate state synchronised back to clk0 as an acknowledge.
module clkmux_gate_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk0,
    input  logic src_clk,
    input  logic rst_n,
    input  logic force_clr,
    input  logic en_req,
    output logic gate,
    output logic ack_clk0
);
    // force_clr is a registered clk0 pulse, so this clear never glitches.
    logic                   clr_n;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   gate_reg;
    logic [1:0]             ack_reg;

    assign clr_n = rst_n & ~force_clr;

    // Bring the enable request into the source domain
    always_ff @(posedge src_clk or negedge clr_n) begin
        if (!clr_n) sync_reg <= '0;
        else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], en_req};
    end

    // Gate flop changes only while the source is low
    always_ff @(negedge src_clk or negedge clr_n) begin
        if (!clr_n) gate_reg <= 1'b0;
        else        gate_reg <= sync_reg[SYNC_STAGES-1];
    end

    // Report the gate state back to the control domain
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) ack_reg <= 2'b00;
        else        ack_reg <= {ack_reg[0], gate_reg};
    end

    assign gate     = gate_reg;
    assign ack_clk0 = ack_reg[1];
endmodule

// File: rtl/clkmux_nx1_hs.sv
// N:1 glitch-free clock mux: valid/ready select, break-before-make switching,
// per-phase dead-clock timeout and fallback to clk0.
module clkmux_nx1_hs
    import clkmux_pkg::*;
#(
    parameter int N           = 4,
    parameter int SEL_W       = $clog2(N),
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int DEFAULT_SEL = 0
) (
    input  logic            clk0,
    input  logic            rst_n,
    input  logic [N-2:0]    clk_src,
    clkmux_nx1_hs_if.slave  ctl,
    output logic            clko
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   cur_sel_reg, cur_sel_next;
    logic [SEL_W-1:0]   target_reg, target_next;
    logic [N-1:0]       en_req_reg, en_req_next;
    logic [N-1:0]       force_clr_reg, force_clr_next;
    logic               err_reg, err_next;
    logic [1:0]         err_code_reg, err_code_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               timeout;

    logic [N-1:0]       src_clk;
    logic [N-1:0]       gate;
    logic [N-1:0]       ack;
    logic [N-1:0]       gated;

    assign src_clk = {clk_src, clk0};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cell
            clkmux_gate_cell #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cell (
                .clk0      (clk0),
                .src_clk   (src_clk[gi]),
                .rst_n     (rst_n),
                .force_clr (force_clr_reg[gi]),
                .en_req    (en_req_reg[gi]),
                .gate      (gate[gi]),
                .ack_clk0  (ack[gi])
            );
            assign gated[gi] = src_clk[gi] & gate[gi];
        end
    endgenerate

    assign clko = |gated;

    // Control state registers
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            cur_sel_reg   <= SEL_W'(DEFAULT_SEL);
            target_reg    <= SEL_W'(DEFAULT_SEL);
            en_req_reg    <= '0;
            force_clr_reg <= '0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cur_sel_reg   <= cur_sel_next;
            target_reg    <= target_next;
            en_req_reg    <= en_req_next;
            force_clr_reg <= force_clr_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
            cnt_reg       <= cnt_next;
        end
    end

    // Next-state logic: handshake, switch sequencing, timeouts
    always_comb begin
        state_next     = state_reg;
        cur_sel_next   = cur_sel_reg;
        target_next    = target_reg;
        en_req_next    = en_req_reg;
        force_clr_next = '0;
        err_next       = err_reg;
        err_code_next  = err_code_reg;
        timeout        = (cnt_reg == CNT_W'(TIMEOUT - 1));

        case (state_reg)
            ST_INIT: begin
                en_req_next[DEFAULT_SEL] = 1'b1;
                if (ack[DEFAULT_SEL]) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (ctl.sel_valid) begin
                    if (int'(ctl.sel) >= N) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_RANGE;
                    end else if (ctl.sel == cur_sel_reg) begin
                        err_next      = 1'b0;
                        err_code_next = ERR_NONE;
                    end else begin
                        err_next                 = 1'b0;
                        err_code_next            = ERR_NONE;
                        target_next              = ctl.sel;
                        en_req_next[cur_sel_reg] = 1'b0;
                        state_next               = ST_OFF_WAIT;
                    end
                end
            end
            ST_OFF_WAIT: begin
                if (!ack[cur_sel_reg]) begin
                    en_req_next[target_reg] = 1'b1;
                    state_next              = ST_ON_WAIT;
                end else if (timeout) begin
                    // Outgoing source is dead: tear its cell down forcibly.
                    force_clr_next[cur_sel_reg] = 1'b1;
                    en_req_next[target_reg]     = 1'b1;
                    err_next                    = 1'b1;
                    err_code_next               = ERR_OFF_TO;
                    state_next                  = ST_ON_WAIT;
                end
            end
            ST_ON_WAIT: begin
                if (ack[target_reg]) begin
                    cur_sel_next = target_reg;
                    state_next   = ST_IDLE;
                end else if (timeout) begin
                    en_req_next[target_reg]    = 1'b0;
                    force_clr_next[target_reg] = 1'b1;
                    err_next                   = 1'b1;
                    err_code_next              = ERR_ON_TO;
                    state_next                 = ST_FALLBACK;
                end
            end
            ST_FALLBACK: begin
                en_req_next[0] = 1'b1;
                if (ack[0]) begin
                    cur_sel_next = '0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_INIT;
        endcase

        // Phase timer restarts on every state change and holds at the limit
        if (state_next != state_reg) cnt_next = '0;
        else if (timeout)            cnt_next = cnt_reg;
        else                         cnt_next = cnt_reg + CNT_W'(1);
    end

    assign ctl.sel_ready = (state_reg == ST_IDLE);
    assign ctl.busy      = (state_reg != ST_IDLE);
    assign ctl.cur_sel   = cur_sel_reg;
    assign ctl.err       = err_reg;
    assign ctl.err_code  = err_code_reg;
endmodule

// File: tb/tb_clkmux_nx1_hs.sv
// Directed bench for clkmux_nx1_hs: reset, normal switch, enable/disable timeouts,
// range error, async reset mid-switch. Time unit scaled: clk0 period 100 ("10 ns").
module tb_clkmux_nx1_hs;
    logic clk0 = 1'b0;
    logic clk1 = 1'b0;
    logic clk2 = 1'b0;
    logic clk3 = 1'b0;
    logic clk1_en = 1'b1;
    logic rst_n = 1'b1;
    logic clko;

    int checks = 0;
    int errors = 0;

    // Pulse-width monitor on clko
    logic mon_en = 1'b0;
    int   short_cnt = 0;
    time  last_t = 0;

    clkmux_nx1_hs_if #(.SEL_W(3)) ifc ();

    clkmux_nx1_hs #(
        .N(4), .SEL_W(3), .SYNC_STAGES(2), .TIMEOUT(1024), .DEFAULT_SEL(0)
    ) dut (
        .clk0    (clk0),
        .rst_n   (rst_n),
        .clk_src ({clk3, clk2, clk1}),
        .ctl     (ifc.slave),
        .clko    (clko)
    );

    always #50 clk0 = ~clk0;
    always begin
        #60;
        if (clk1_en) clk1 = ~clk1;
    end
    always #35 clk2 = ~clk2;
    // clk3 never toggles: a dead source

    always @(clko) begin
        if (mon_en && (($time - last_t) < 35)) short_cnt++;
        last_t = $time;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [2:0] s);
        @(negedge clk0);
        ifc.sel = s;
        ifc.sel_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (ifc.sel_ready === 1'b1) break;
            @(negedge clk0);
        end
        chk("req_ready", ifc.sel_ready, 1);
        @(negedge clk0);
        ifc.sel_valid = 1'b0;
        $display("REQ sel=%0d busy=%0d cur_sel=%0d err=%0d err_code=%0d",
                 s, ifc.busy, ifc.cur_sel, ifc.err, ifc.err_code);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk0);
            if (ifc.sel_ready === 1'b1) break;
        end
        chk(tag, ifc.sel_ready, 1);
    endtask

    task automatic follow_clk0(input string tag);
        repeat (3) begin
            @(posedge clk0); #1 chk(tag, clko, 1);
            @(negedge clk0); #1 chk(tag, clko, 0);
        end
    endtask

    task automatic follow_clk2(input string tag);
        repeat (3) begin
            @(posedge clk2); #1 chk(tag, clko, 1);
            @(negedge clk2); #1 chk(tag, clko, 0);
        end
    endtask

    initial begin
        ifc.sel = '0;
        ifc.sel_valid = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        #20;
        chk("rst_ready", ifc.sel_ready, 0);
        chk("rst_busy", ifc.busy, 1);
        chk("rst_cur_sel", ifc.cur_sel, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_err_code", ifc.err_code, 0);
        chk("rst_clko", clko, 0);
        @(negedge clk0);
        rst_n = 1'b1;

        // INIT enables source 0 within a handful of clk0 cycles
        wait_idle(10, "init_idle");
        chk("init_busy", ifc.busy, 0);
        chk("init_cur_sel", ifc.cur_sel, 0);
        chk("init_err_code", ifc.err_code, 0);
        follow_clk0("init_follow_clk0");

        // Normal switch 0 -> 2, no short pulses
        short_cnt = 0;
        mon_en = 1'b1;
        do_req(3'd2);
        chk("sw2_busy", ifc.busy, 1);
        wait_idle(60, "sw2_idle");
        chk("sw2_cur_sel", ifc.cur_sel, 2);
        chk("sw2_err", ifc.err, 0);
        follow_clk2("sw2_follow_clk2");
        mon_en = 1'b0;
        chk("sw2_short_pulses", short_cnt, 0);

        // Dead target 3: enable timeout, fallback to clk0
        do_req(3'd3);
        wait_idle(2000, "on_to_idle");
        chk("on_to_err", ifc.err, 1);
        chk("on_to_err_code", ifc.err_code, 3);
        chk("on_to_cur_sel", ifc.cur_sel, 0);
        follow_clk0("on_to_follow_clk0");

        // Select clk1, then kill it and switch to clk2: disable timeout
        do_req(3'd1);
        wait_idle(60, "sw1_idle");
        chk("sw1_cur_sel", ifc.cur_sel, 1);
        chk("sw1_err", ifc.err, 0);
        @(negedge clk1);
        clk1_en = 1'b0;
        do_req(3'd2);
        wait_idle(2000, "off_to_idle");
        chk("off_to_err", ifc.err, 1);
        chk("off_to_err_code", ifc.err_code, 2);
        chk("off_to_cur_sel", ifc.cur_sel, 2);
        follow_clk2("off_to_follow_clk2");

        // Out-of-range select, then same-source request clears err undisturbed
        short_cnt = 0;
        mon_en = 1'b1;
        do_req(3'd5);
        chk("range_err", ifc.err, 1);
        chk("range_err_code", ifc.err_code, 1);
        chk("range_cur_sel", ifc.cur_sel, 2);
        chk("range_ready", ifc.sel_ready, 1);
        do_req(3'd2);
        chk("same_err", ifc.err, 0);
        chk("same_err_code", ifc.err_code, 0);
        chk("same_busy", ifc.busy, 0);
        chk("same_cur_sel", ifc.cur_sel, 2);
        follow_clk2("same_follow_clk2");
        mon_en = 1'b0;
        chk("same_short_pulses", short_cnt, 0);

        // Async reset in the middle of ON_WAIT towards dead clk3
        do_req(3'd3);
        repeat (50) @(negedge clk0);
        chk("onwait_busy", ifc.busy, 1);
        #13 rst_n = 1'b0;
        #1;
        chk("arst_clko", clko, 0);
        chk("arst_gates", dut.gate, 0);
        chk("arst_busy", ifc.busy, 1);
        chk("arst_ready", ifc.sel_ready, 0);
        chk("arst_cur_sel", ifc.cur_sel, 0);
        chk("arst_err", ifc.err, 0);
        @(negedge clk0);
        rst_n = 1'b1;
        wait_idle(10, "reinit_idle");
        chk("reinit_cur_sel", ifc.cur_sel, 0);
        chk("reinit_err_code", ifc.err_code, 0);
        follow_clk0("reinit_follow_clk0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clkmux_nx1_hs.md
Name: clkmux_nx1_hs

Overview:
- Parametrised N-input glitch-free clock multiplexer; successor to the fixed 2:1/4:1 muxes.
- Adds a valid/ready select handshake, busy/status reporting, per-source dead-clock timeout and automatic fallback to clk0.
- clk0 is both source 0 and the control-domain clock. It must be a free-running, always-alive clock, such as the on-chip RC oscillator.
- Sits at the root of the SoC clock tree, feeding the clock divider/gating stages.

Parameters:
- N, 4, number of clock sources (2..16); source 0 is clk0.
- SEL_W, $clog2(N), select width.
- SYNC_STAGES, 2, posedge synchroniser flops per source before the negedge gate flop (min 2).
- TIMEOUT, 1024, clk0 cycles allowed for any single disable or enable phase.
- DEFAULT_SEL, 0, source enabled after reset.

Ports:
- clk0  in  1  control clock and source 0.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_src  in  N-1  sources 1..N-1 (clk_src[i-1] = source i).
- sel  in  SEL_W  requested source.
- sel_valid  in  1  request valid (clk0 domain).
- sel_ready  out  1  request accepted when valid&ready.
- busy  out  1  switch in progress.
- cur_sel  out  SEL_W  source currently driving clko.
- err  out  1  sticky error; cleared on the next accepted request.
- err_code  out  2  0 none, 1 sel out of range, 2 disable timeout, 3 enable timeout.
- clko  out  1  muxed clock.

Behaviour:
- Reset values:
  - All gate and sync flops 0; clko = 0.
  - sel_ready = 0, busy = 1, cur_sel = DEFAULT_SEL, err = 0, err_code = 0.
- Per-source gate cell:
  - en_req[i] (clk0 domain) passes through SYNC_STAGES posedge flops of source i, then one negedge flop giving gate[i].
  - clko = OR over i of (src[i] & gate[i]).
  - gate[i] is synchronised back to clk0 by 2 flops as ack[i].
- FSM (clk0 domain), states INIT, IDLE, OFF_WAIT, ON_WAIT, FALLBACK:
  - INIT: en_req[DEFAULT_SEL] = 1. Wait for ack[DEFAULT_SEL] = 1, then go to IDLE.
  - IDLE: sel_ready = 1, busy = 0. On valid&ready:
    - sel >= N: err = 1, err_code = 1, stay in IDLE.
    - sel == cur_sel: accept, clear err, no switching; ready stays 1 next cycle.
    - Otherwise: latch target, clear err, drop en_req[cur_sel], go to OFF_WAIT.
  - OFF_WAIT: wait for ack[cur_sel] = 0, then raise en_req[target] and go to ON_WAIT.
    - On timeout (current source dead): pulse force_clr[cur_sel], which asynchronously clears that cell's flops, then proceed to ON_WAIT. err = 1, err_code = 2.
  - ON_WAIT: on ack[target] = 1, cur_sel = target, go to IDLE.
    - On timeout: drop en_req[target], pulse force_clr[target], err = 1, err_code = 3, go to FALLBACK.
  - FALLBACK: raise en_req[0]. Wait for ack[0], then cur_sel = 0 and go to IDLE (no timeout, clk0 is alive).
- Timeout counter:
  - Width $clog2(TIMEOUT+1); reloads to 0 on each state entry.
  - Timeout fires when it reaches TIMEOUT-1.
- Invariant: at most one gate[i] = 1 at any time, except during a forced clear. No clko pulse is shorter than the shorter half-period of the outgoing or incoming source.
- Latency:
  - Disable phase ≈ SYNC_STAGES + 1 old-source cycles + 2 clk0 cycles.
  - Enable phase is the same using new-source cycles.
  - sel_ready reasserts the cycle after the final ack is seen.
- sel and sel_valid are ignored while busy; the requester holds valid.
- An async rst_n during any state returns to the reset values; INIT then re-enables DEFAULT_SEL.
- Forced clear is the only permitted non-glitch-free path. It is accepted only because the affected source has stopped.

Decomposition:
- Package clkmux_pkg:
  - FSM state enum.
  - err_code localparams ERR_NONE, ERR_RANGE, ERR_OFF_TO, ERR_ON_TO.
- Sub-module clkmux_gate_cell:
  - Ports: src_clk, rst_n, force_clr, en_req, gate, ack_clk0.
  - Contains SYNC_STAGES posedge flops, the negedge gate flop and the 2-flop ack synchroniser.
  - Instantiated N times via generate.

Test Plan:
- Reset release, clk0 = 10 ns: within 2+1+2 clk0 cycles ack[0] = 1 and clko toggles with clk0. Then sel_ready = 1, busy = 0, cur_sel = 0, err_code = 0.
- sel = 2 with valid, clk2 = 7 ns (async phase): busy rises, clko stays low through the handover, then follows clk2. No high or low pulse < 3.5 ns; cur_sel = 2, err = 0.
- Target clk3 held at 0, sel = 3: after 1024 clk0 cycles in ON_WAIT, err_code = 3. clko returns to clk0; cur_sel = 0.
- Current source clk1 stopped while selected, then sel = 2: disable timeout gives err_code = 2. clko then follows clk2 and cur_sel = 2.
- N = 4, sel = 5: no switch, err = 1, err_code = 1. A following sel = cur_sel request clears err with no clko disturbance.
- rst_n pulsed low during ON_WAIT: clko = 0 and all gates 0 immediately. After release, the INIT sequence completes with cur_sel = DEFAULT_SEL.
